// File: rtl/mtimer_mmap.sv
// Memory-mapped machine timer: prescaled free-running 64-bit mtime plus
// CHANNELS 64-bit compare channels, each driving a registered level interrupt.
module mtimer_mmap #(
    parameter int CHANNELS   = 1,
    parameter int PRESCALE_W = 16,
    parameter int ADDR_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sel,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [31:0]         wd,
    input  logic [3:0]          wbe,
    output logic [31:0]         rd,
    output logic [63:0]         mtime,
    output logic [CHANNELS-1:0] irq
);
    localparam logic [ADDR_W-1:0] OFS_MTIME_LO = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] OFS_MTIME_HI = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] OFS_CTRL     = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] OFS_PRESCALE = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] OFS_STATUS   = ADDR_W'(32'h10);

    logic [63:0]           mtime_q;
    logic                  en_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] pcnt_q;
    logic [63:0]           cmp_q [CHANNELS];
    logic [CHANNELS-1:0]   irq_q;

    logic [ADDR_W-1:0] ofs;
    logic              wr;
    logic              wr_mlo;
    logic              wr_mhi;
    logic              wr_ctrl;
    logic              wr_pre;
    logic              tick;
    logic              unused_addr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] data,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = be[b] ? data[8*b +: 8] : cur[8*b +: 8];
        return res;
    endfunction

    assign ofs              = {addr[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^addr[1:0];
    assign wr               = sel && we;
    assign wr_mlo           = wr && (ofs == OFS_MTIME_LO);
    assign wr_mhi           = wr && (ofs == OFS_MTIME_HI);
    assign wr_ctrl          = wr && (ofs == OFS_CTRL);
    assign wr_pre           = wr && (ofs == OFS_PRESCALE);
    assign tick             = en_q && (pcnt_q == prescale_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_q    <= '0;
            en_q       <= 1'b1;
            prescale_q <= '0;
            pcnt_q     <= '0;
            irq_q      <= '0;
            for (int i = 0; i < CHANNELS; i++)
                cmp_q[i] <= '1;
        end else begin
            // Prescale write restarts the count; otherwise pcnt runs while enabled.
            if (wr_pre)
                pcnt_q <= '0;
            else if (en_q)
                pcnt_q <= tick ? '0 : pcnt_q + PRESCALE_W'(1);

            if (wr_pre)
                prescale_q <= PRESCALE_W'(merge_bytes(32'(prescale_q), wd, wbe));
            if (wr_ctrl && wbe[0])
                en_q <= wd[0];

            // A software write to either half swallows that cycle's tick.
            if (wr_mlo)
                mtime_q[31:0] <= merge_bytes(mtime_q[31:0], wd, wbe);
            else if (wr_mhi)
                mtime_q[63:32] <= merge_bytes(mtime_q[63:32], wd, wbe);
            else if (tick)
                mtime_q <= mtime_q + 64'd1;

            for (int i = 0; i < CHANNELS; i++) begin
                if (wr && (ofs == ADDR_W'(32 + 8*i)))
                    cmp_q[i][31:0] <= merge_bytes(cmp_q[i][31:0], wd, wbe);
                if (wr && (ofs == ADDR_W'(36 + 8*i)))
                    cmp_q[i][63:32] <= merge_bytes(cmp_q[i][63:32], wd, wbe);
                irq_q[i] <= (mtime_q >= cmp_q[i]);
            end
        end
    end

    always_comb begin
        rd = '0;
        case (ofs)
            OFS_MTIME_LO: rd = mtime_q[31:0];
            OFS_MTIME_HI: rd = mtime_q[63:32];
            OFS_CTRL:     rd = {31'd0, en_q};
            OFS_PRESCALE: rd = 32'(prescale_q);
            OFS_STATUS:   rd = 32'(irq_q);
            default:      rd = '0;
        endcase
        for (int i = 0; i < CHANNELS; i++) begin
            if (ofs == ADDR_W'(32 + 8*i))
                rd = cmp_q[i][31:0];
            if (ofs == ADDR_W'(36 + 8*i))
                rd = cmp_q[i][63:32];
        end
    end

    assign mtime = mtime_q;
    assign irq   = irq_q;

endmodule
